// File: rtl/glb_stream_agen.sv
// glb_stream_agen: L-level nested-loop GLB address sequencer driving a read
// stream (GLB -> out) or a write stream (in -> GLB) with a 2-entry skid FIFO.
module glb_stream_agen #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned STR_W     = 16,
  parameter int unsigned L         = 4,
  parameter int unsigned BE_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [L*CNT_W-1:0]   ext,
  input  logic [L*STR_W-1:0]   stride,
  input  logic [BE_W-1:0]      be_mask,
  output logic                 busy,
  output logic                 done,
  output logic [BE_W-1:0]      glb_re,
  output logic [ADDR_W-1:0]    glb_r_addr,
  input  logic [DATA_SIZE-1:0] glb_r_data,
  output logic [BE_W-1:0]      glb_we,
  output logic [ADDR_W-1:0]    glb_w_addr,
  output logic [DATA_SIZE-1:0] glb_w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [L*CNT_W-1:0]   out_idx,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic [L*CNT_W-1:0]   cur_idx
);
  localparam int unsigned IDX_W = L * CNT_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  // Latched job configuration
  logic              mode_q;
  logic [BE_W-1:0]   be_q;
  logic [CNT_W-1:0]  ext_q [L];
  logic [STR_W-1:0]  str_q [L];

  // Loop indices; lvl_addr_q[i] = base + sum over j>=i of idx_j*stride_j
  logic [CNT_W-1:0]  idx_q [L];
  logic [ADDR_W-1:0] lvl_addr_q [L];

  // Read skid FIFO and the single read that can be in flight
  logic [DATA_SIZE-1:0] fifo_data_q [2];
  logic [IDX_W-1:0]     fifo_idx_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           count_q, count_nxt;
  logic                 rd_pend_q;
  logic [IDX_W-1:0]     pend_idx_q;

  logic [IDX_W-1:0]     idx_flat;
  logic [L-1:0]         carry, inc;
  logic [ADDR_W-1:0]    step_addr;
  logic                 is_last, ext_zero;
  logic                 issue, wr_fire, adv, flush;
  logic                 head_valid, push, fifo_pop;
  logic [DATA_SIZE-1:0] head_data;
  logic [IDX_W-1:0]     head_idx;

  // Carry chain: inc marks the one level that steps; carry marks it and all levels below
  always_comb begin
    logic c, m;
    c         = 1'b1;
    m         = 1'b0;
    ext_zero  = 1'b0;
    step_addr = '0;
    idx_flat  = '0;
    carry     = '0;
    inc       = '0;
    for (int i = 0; i < L; i++) begin
      idx_flat[i*CNT_W +: CNT_W] = idx_q[i];
      m        = (idx_q[i] == ext_q[i] - CNT_W'(1));
      carry[i] = c;
      inc[i]   = c & ~m;
      if (c && !m) step_addr = lvl_addr_q[i] + ADDR_W'(str_q[i]);
      c = c & m;
      if (ext[i*CNT_W +: CNT_W] == '0) ext_zero = 1'b1;
    end
    is_last = c;
  end

  // Issue / handshake / FIFO bookkeeping; an empty FIFO bypasses returning data to the head
  always_comb begin
    flush      = abort && (state != IDLE);
    issue      = (state == RUN) && !mode_q && ((count_q + 2'(rd_pend_q)) < 2'd2);
    wr_fire    = (state == RUN) && mode_q && in_valid;
    adv        = issue || wr_fire;
    head_valid = (count_q != 2'd0) || rd_pend_q;
    head_data  = (count_q != 2'd0) ? fifo_data_q[rd_ptr_q] : glb_r_data;
    head_idx   = (count_q != 2'd0) ? fifo_idx_q[rd_ptr_q] : pend_idx_q;
    fifo_pop   = out_ready && (count_q != 2'd0);
    push       = rd_pend_q && !((count_q == 2'd0) && out_ready);
    count_nxt  = count_q + 2'(push) - 2'(fifo_pop);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and outputs; abort overrides everything else
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    in_ready   = 1'b0;
    glb_re     = '0;
    glb_r_addr = '0;
    glb_we     = '0;
    glb_w_addr = '0;
    glb_w_data = '0;
    out_valid  = head_valid;
    out_data   = head_valid ? head_data : '0;
    out_idx    = head_valid ? head_idx : '0;
    cur_idx    = idx_flat;
    case (state)
      IDLE: if (start) state_nxt = ext_zero ? DONE : RUN;
      RUN: begin
        in_ready = mode_q;
        if (issue) begin
          glb_re     = be_q;
          glb_r_addr = lvl_addr_q[0];
        end
        if (wr_fire) begin
          glb_we     = be_q;
          glb_w_addr = lvl_addr_q[0];
          glb_w_data = in_data;
        end
        if (adv && is_last) state_nxt = mode_q ? DONE : DRAIN;
      end
      DRAIN: if (count_nxt == 2'd0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Job latch and incremental index/address advance (held on the last element)
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      be_q   <= '0;
      for (int i = 0; i < L; i++) begin
        ext_q[i]      <= '0;
        str_q[i]      <= '0;
        idx_q[i]      <= '0;
        lvl_addr_q[i] <= '0;
      end
    end else if ((state == IDLE) && start) begin
      mode_q <= mode;
      be_q   <= be_mask;
      for (int i = 0; i < L; i++) begin
        ext_q[i]      <= ext[i*CNT_W +: CNT_W];
        str_q[i]      <= stride[i*STR_W +: STR_W];
        idx_q[i]      <= '0;
        lvl_addr_q[i] <= base_addr;
      end
    end else if (adv && !is_last) begin
      for (int i = 0; i < L; i++) begin
        if (inc[i])        idx_q[i] <= idx_q[i] + CNT_W'(1);
        else if (carry[i]) idx_q[i] <= '0;
        if (carry[i]) lvl_addr_q[i] <= step_addr;
      end
    end
  end

  // FIFO pointers, occupancy and in-flight flag; abort drops everything including the pending read
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      count_q   <= count_nxt;
      rd_pend_q <= issue;
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // FIFO storage and the index tuple of the read in flight
  always_ff @(posedge clk) begin
    if (issue) pend_idx_q <= idx_flat;
    if (push) begin
      fifo_data_q[wr_ptr_q] <= glb_r_data;
      fifo_idx_q[wr_ptr_q]  <= pend_idx_q;
    end
  end

endmodule

// File: tb/tb_glb_stream_agen.sv
// Bench for glb_stream_agen: directed and randomized jobs checked against a
// flat-count nested-loop reference model and a simple GLB read model.
module tb_glb_stream_agen;
  logic        clk = 1'b0;
  logic        rst, start, abort, mode;
  logic [31:0] base_addr;
  logic [31:0] ext;
  logic [63:0] stride;
  logic [3:0]  be_mask;
  logic        busy, done;
  logic [3:0]  glb_re, glb_we;
  logic [31:0] glb_r_addr, glb_r_data, glb_w_addr, glb_w_data;
  logic        out_valid, out_ready, in_valid, in_ready;
  logic [31:0] out_data, out_idx, in_data, cur_idx;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] salt = 32'h0;
  logic [31:0] j_base;
  int          j_ext [4];
  int          j_str [4];
  logic [3:0]  j_be;
  logic [31:0] exp_addr [$];
  logic [31:0] exp_idx  [$];

  glb_stream_agen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .ext(ext), .stride(stride), .be_mask(be_mask),
    .busy(busy), .done(done),
    .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  // GLB read port: data for an address requested in one cycle appears in the next
  always @(posedge clk) begin
    if (glb_re != '0) glb_r_data <= data_of(glb_r_addr);
    else              glb_r_data <= $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input logic [31:0] b, input int e0, input int e1, input int e2, input int e3,
                         input int s0, input int s1, input int s2, input int s3, input logic [3:0] be);
    j_base = b; j_be = be;
    j_ext[0] = e0; j_ext[1] = e1; j_ext[2] = e2; j_ext[3] = e3;
    j_str[0] = s0; j_str[1] = s1; j_str[2] = s2; j_str[3] = s3;
  endtask

  task automatic rand_job();
    j_base = $urandom; j_be = 4'($urandom_range(1, 15));
    for (int i = 0; i < 4; i++) begin
      j_ext[i] = $urandom_range(1, 3);
      j_str[i] = $urandom_range(0, 65535);
    end
  endtask

  // Element n of the flattened loop nest: idx_i = (n / prod_{j<i} ext_j) mod ext_i
  task automatic build_expect(output int total);
    total = 1;
    for (int i = 0; i < 4; i++) total = total * j_ext[i];
    exp_addr.delete();
    exp_idx.delete();
    for (int n = 0; n < total; n++) begin
      int r;
      logic [31:0] a, ix;
      r = n; a = j_base; ix = '0;
      for (int i = 0; i < 4; i++) begin
        int v;
        v = r % j_ext[i];
        r = r / j_ext[i];
        a = a + 32'(v * j_str[i]);
        ix[i*8 +: 8] = 8'(v);
      end
      exp_addr.push_back(a);
      exp_idx.push_back(ix);
    end
  endtask

  task automatic kick(input logic m);
    @(negedge clk);
    salt = $urandom;
    start = 1'b1; abort = 1'b0; mode = m;
    base_addr = j_base; be_mask = j_be;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ext[i*8 +: 8]     = 8'(j_ext[i]);
      stride[i*16 +: 16] = 16'(j_str[i]);
    end
  endtask

  task automatic scramble();
    start = 1'b0; mode = 1'($urandom); base_addr = $urandom; ext = $urandom;
    stride = {$urandom, $urandom}; be_mask = 4'($urandom);
  endtask

  // rdy_pat: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random
  task automatic run_read(input int rdy_pat, input int abort_at, input int start_at);
    int total, issued, delivered, last_hs;
    logic [31:0] prev_data;
    logic prev_stall;
    bit fin, aborted;
    build_expect(total);
    issued = 0; delivered = 0; last_hs = 0; prev_data = '0; prev_stall = 1'b0;
    fin = 1'b0; aborted = 1'b0;
    kick(1'b0);
    for (int cyc = 1; cyc <= 1000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) scramble();
      start = (cyc == start_at);
      abort = (cyc == abort_at);
      case (rdy_pat)
        0:       out_ready = 1'b1;
        1:       out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (done) begin
        chk("done_count", delivered, total);
        chk("done_timing", cyc, last_hs + 1);
        chk("done_busy", 32'(busy), 32'd1);
        fin = 1'b1;
      end else begin
        chk("busy", 32'(busy), 32'd1);
        if (glb_re != '0) begin
          if (issued < total) begin
            chk("re_mask", 32'(glb_re), 32'(j_be));
            chk("r_addr", glb_r_addr, exp_addr[issued]);
            if (rdy_pat == 0) chk("r_back_to_back", cyc, issued + 1);
          end else chk("extra_read", 32'(glb_re), 32'd0);
          issued++;
          chk("occupancy_le2", 32'((issued - delivered) <= 2), 32'd1);
        end
        if (out_valid) begin
          if (delivered < total) begin
            chk("out_data", out_data, data_of(exp_addr[delivered]));
            chk("out_idx", out_idx, exp_idx[delivered]);
          end else chk("extra_out", 32'(out_valid), 32'd0);
          if (prev_stall) chk("stall_stable", out_data, prev_data);
          if (rdy_pat == 0 && delivered == 0) chk("first_valid_latency", cyc, 32'd2);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
          delivered++;
          last_hs = cyc;
        end
      end
      if (cyc == abort_at) begin
        @(negedge clk);
        abort = 1'b0; start = 1'b0; #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (4) begin
          @(negedge clk); #1;
          chk("abort_no_done", 32'(done), 32'd0);
          chk("abort_no_read", 32'(glb_re), 32'd0);
        end
        fin = 1'b1; aborted = 1'b1;
      end
    end
    if (!fin) chk("read_timeout_done", 32'(done), 32'd1);
    if (!aborted) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; out_ready = 1'b0; #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  endtask

  // vld_pat: 0 = valid on odd cycles, 1 = random
  task automatic run_write(input int vld_pat);
    int total, written, last_hs;
    bit fin;
    build_expect(total);
    written = 0; last_hs = 0; fin = 1'b0;
    kick(1'b1);
    for (int cyc = 1; cyc <= 1000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) scramble();
      in_valid = (vld_pat == 0) ? ((cyc % 2) == 1) : 1'($urandom_range(0, 1));
      in_data  = $urandom;
      #1;
      if (done) begin
        chk("wdone_count", written, total);
        chk("wdone_timing", cyc, last_hs + 1);
        chk("we_at_done", 32'(glb_we), 32'd0);
        fin = 1'b1;
      end else begin
        chk("wbusy", 32'(busy), 32'd1);
        chk("in_ready", 32'(in_ready), 32'd1);
        if (in_valid && written < total) begin
          chk("we_mask", 32'(glb_we), 32'(j_be));
          chk("w_addr", glb_w_addr, exp_addr[written]);
          chk("w_data", glb_w_data, in_data);
          chk("cur_idx", cur_idx, exp_idx[written]);
          written++;
          last_hs = cyc;
        end else chk("we_idle", 32'(glb_we), 32'd0);
      end
    end
    if (!fin) chk("write_timeout_done", 32'(done), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("widle_busy", 32'(busy), 32'd0);
    chk("widle_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_re"},    32'(glb_re), 32'd0);
    chk({tag, "_we"},    32'(glb_we), 32'd0);
    chk({tag, "_raddr"}, glb_r_addr, 32'd0);
    chk({tag, "_waddr"}, glb_w_addr, 32'd0);
    chk({tag, "_oval"},  32'(out_valid), 32'd0);
    chk({tag, "_irdy"},  32'(in_ready), 32'd0);
    chk({tag, "_odata"}, out_data, 32'd0);
    chk({tag, "_oidx"},  out_idx, 32'd0);
    chk({tag, "_cidx"},  cur_idx, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; base_addr = '0; ext = '0;
    stride = '0; be_mask = '0; out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Two-level read, always ready: 0x100,0x104,0x108,0x140,0x144,0x148
    set_job(32'h100, 3, 2, 1, 1, 4, 64, 0, 0, 4'hF);
    run_read(0, -1, -1);
    // Same job with out_ready toggling 1,0,0,1
    run_read(1, -1, -1);
    // Gapped write stream with partial byte enables
    set_job(32'h200, 4, 1, 1, 1, 4, 0, 0, 0, 4'b0011);
    run_write(0);
    // Zero extent: immediate done, no GLB access
    set_job(32'h300, 5, 0, 2, 1, 4, 8, 8, 8, 4'hF);
    run_read(0, -1, -1);
    run_write(1);
    // Abort on the 3rd cycle of a 16-element read, then a fresh job
    set_job(32'h400, 16, 1, 1, 1, 4, 0, 0, 0, 4'hF);
    run_read(0, 3, -1);
    set_job(32'h800, 4, 2, 1, 1, 4, 32, 0, 0, 4'hF);
    run_read(0, -1, -1);
    // Address wrap-around, with a start pulse during RUN that must be ignored
    set_job(32'hFFFF_FFFC, 3, 1, 1, 1, 4, 0, 0, 0, 4'hF);
    run_read(0, -1, 2);

    // Reset in the middle of a job
    set_job(32'h1000, 8, 1, 1, 1, 4, 0, 0, 0, 4'hF);
    kick(1'b0);
    @(negedge clk);
    scramble(); out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 chk_all_zero("midrst");
    rst = 1'b0; out_ready = 1'b0;
    set_job(32'h2000, 2, 3, 1, 1, 8, 128, 0, 0, 4'hF);
    run_read(2, -1, -1);

    // Randomized jobs
    for (int k = 0; k < 4; k++) begin
      rand_job();
      run_read(2, -1, -1);
    end
    for (int k = 0; k < 3; k++) begin
      rand_job();
      run_write(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
